enoc_switch_allocator: RTL and testbench

Per-router switch allocator for the ENoC 5-port router. It takes the one-hot output-port requests produced by each input port's route calculator ([c,n,e,s,w] order) and shares each output port between competing inputs. Arbitration is round-robin per output, gated by downstream readiness. With wormhole locking compiled in, an output stays locked to one input from a packet's head flit through its tail flit. It sits between the route calculators and the crossbar/input-buffer read enables.

---
 rtl/enoc_pkg.sv | 17 +
 rtl/enoc_output_arbiter.sv | 103 ++++++++++
 rtl/enoc_switch_allocator.sv | 52 +++++
 tb/tb_enoc_switch_allocator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/enoc_pkg.sv
// Shared ENoC router definitions: port count, port indices, output lock states.
package enoc_pkg;

    localparam int PORTS = 5;

    localparam int C = 0;
    localparam int N = 1;
    localparam int E = 2;
    localparam int S = 3;
    localparam int W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/enoc_output_arbiter.sv
// Round-robin arbiter for one router output port, with an optional wormhole lock.
// The lock is compiled in only when ENOC_WORMHOLE_LOCK_EN is defined.
//
// state  | meaning
// IDLE   | any requesting input may win, searching from ptr
// LOCKED | only the owner may be granted until its tail flit transfers
module enoc_output_arbiter
    import enoc_pkg::*;
#(
    parameter int PORTS = enoc_pkg::PORTS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:PORTS-1] req,
    input  logic [0:PORTS-1] tail,
    input  logic             en,
    output logic [0:PORTS-1] grant
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    ptr_inc;
    logic [0:PORTS-1] cand;
    logic             found;
    logic             xfer;
    int               idx;

`ifdef ENOC_WORMHOLE_LOCK_EN
    lock_state_t   state;
    logic [PW-1:0] owner;

    always_comb begin
        cand = req;
        if (state == LOCKED) begin
            cand        = '0;
            cand[owner] = req[owner];
        end
    end
`else
    logic unused_tail;

    assign unused_tail = ^tail;

    always_comb begin
        cand = req;
    end
`endif

    // First candidate at or after ptr, wrapping modulo PORTS.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign xfer    = found & en;
    assign ptr_inc = (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;

    always_comb begin
        grant = '0;
        if (xfer && reset_n) begin
            grant[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr   <= '0;
`ifdef ENOC_WORMHOLE_LOCK_EN
            state <= IDLE;
            owner <= '0;
`endif
        end else if (xfer) begin
`ifdef ENOC_WORMHOLE_LOCK_EN
            // While locked the pointer already points past the owner.
            if (state == IDLE) begin
                ptr <= ptr_inc;
                if (!tail[win]) begin
                    state <= LOCKED;
                    owner <= win;
                end
            end else if (tail[owner]) begin
                state <= IDLE;
            end
`else
            ptr <= ptr_inc;
`endif
        end
    end

endmodule

// File: rtl/enoc_switch_allocator.sv
// ENoC 5-port router switch allocator: one round-robin arbiter per output port.
// Wormhole locking is enabled by defining ENOC_WORMHOLE_LOCK_EN.
module enoc_switch_allocator
    import enoc_pkg::*;
#(
    parameter int PORTS = enoc_pkg::PORTS
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [0:PORTS-1][0:PORTS-1] i_output_req,
    input  logic [0:PORTS-1]            i_tail,
    input  logic [0:PORTS-1]            i_en,
    output logic [0:PORTS-1][0:PORTS-1] o_output_grant,
    output logic [0:PORTS-1]            o_input_grant
);

    logic [0:PORTS-1] req_col   [PORTS];
    logic [0:PORTS-1] grant_row [PORTS];

    // Column j of the request matrix is every input's request for output j.
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            req_col[j] = '0;
            for (int i = 0; i < PORTS; i++) begin
                req_col[j][i] = i_output_req[i][j];
            end
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_out
        enoc_output_arbiter #(
            .PORTS (PORTS)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req_col[j]),
            .tail    (i_tail),
            .en      (i_en[j]),
            .grant   (grant_row[j])
        );
    end

    always_comb begin
        o_output_grant = '0;
        o_input_grant  = '0;
        for (int j = 0; j < PORTS; j++) begin
            o_output_grant[j] = grant_row[j];
            o_input_grant     = o_input_grant | grant_row[j];
        end
    end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed bench for enoc_switch_allocator; expectations follow ENOC_WORMHOLE_LOCK_EN.
module tb_enoc_switch_allocator;

`ifdef ENOC_WORMHOLE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [0:4][0:4]  req;
    logic [0:4]       tail;
    logic [0:4]       en;
    logic [0:4][0:4]  o_output_grant;
    logic [0:4]       o_input_grant;

    int errors = 0;
    int checks = 0;

    enoc_switch_allocator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_output_req   (req),
        .i_tail         (tail),
        .i_en           (en),
        .o_output_grant (o_output_grant),
        .o_input_grant  (o_input_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:4] oh(input int i);
        logic [0:4] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic clr();
        req  = '0;
        tail = '0;
    endtask

    task automatic rq(input int i, input int j, input logic t);
        req[i]  = oh(j);
        tail[i] = t;
    endtask

    // i < 0 means no grant anywhere; otherwise only output j grants input i.
    task automatic expect_grant(input string tag, input int j, input int i);
        logic [0:4][0:4] em;
        logic [0:4]      ei;
        em = '0;
        ei = oh(i);
        if (i >= 0) em[j] = oh(i);
        checks++;
        assert (o_output_grant === em) else begin
            errors++;
            $error("FAIL %s out_grant observed=%h expected=%h", tag, o_output_grant, em);
        end
        checks++;
        assert (o_input_grant === ei) else begin
            errors++;
            $error("FAIL %s in_grant observed=%b expected=%b", tag, o_input_grant, ei);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [6]  = '{0, 1, 3, 0, 1, 3};
    int wh_lock [5] = '{2, 2, 2, 2, 4};
    int wh_free [5] = '{2, 4, 2, 4, 2};
    int bp_lock [9] = '{0, -1, -1, -1, -1, -1, 0, 0, 2};
    int bp_free [9] = '{0,  2, -1, -1, -1, -1, 0, 2, 2};

    initial begin
        reset_n = 1'b0;
        en      = 5'b11111;
        clr();

        // Grants forced to zero while reset is held, even with a request.
        rq(1, 2, 1'b1);
        #1;
        expect_grant("reset_hold", 2, -1);
        next_cycle();
        next_cycle();

        // Simple grant: n -> e, same-cycle.
        reset_n = 1'b1;
        #1;
        expect_grant("simple", 2, 1);
        next_cycle();

        // ptr[e] now 2: n and s compete, s must win.
        rq(3, 2, 1'b1);
        #1;
        expect_grant("ptr_after_n", 2, 3);
        next_cycle();
        clr();
        rq(1, 2, 1'b1);
        #1;
        expect_grant("n_alone", 2, 1);
        next_cycle();

        // Round-robin on w among c, n, s.
        clr();
        rq(0, 4, 1'b1);
        rq(1, 4, 1'b1);
        rq(3, 4, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1;
            expect_grant($sformatf("rr_%0d", k), 4, rr_exp[k]);
            next_cycle();
        end

        // Wormhole: e sends head, 2 bodies, tail, then a new head; w competes.
        for (int k = 0; k < 5; k++) begin
            clr();
            rq(2, 3, (k == 3));
            rq(4, 3, 1'b1);
            #1;
            expect_grant($sformatf("worm_%0d", k), 3, LOCK ? wh_lock[k] : wh_free[k]);
            next_cycle();
        end

        // Backpressure on n with c as owner; owner drop, en low, resume, release.
        for (int k = 0; k < 9; k++) begin
            clr();
            if (k != 1 && k != 8) rq(0, 1, (k == 7));
            rq(2, 1, 1'b1);
            en    = 5'b11111;
            en[1] = !(k >= 2 && k <= 5);
            #1;
            expect_grant($sformatf("bp_%0d", k), 1, LOCK ? bp_lock[k] : bp_free[k]);
            next_cycle();
        end
        en = 5'b11111;

        // Reset mid-packet: s takes e with a head flit, then reset drops lock and ptr.
        clr();
        rq(3, 2, 1'b0);
        #1;
        expect_grant("mid_head", 2, 3);
        next_cycle();
        reset_n = 1'b0;
        rq(4, 2, 1'b1);
        #1;
        expect_grant("mid_reset", 2, -1);
        next_cycle();
        reset_n = 1'b1;
        clr();
        rq(1, 2, 1'b1);
        rq(4, 2, 1'b1);
        #1;
        expect_grant("post_reset", 2, 1);
        next_cycle();
        clr();
        rq(4, 2, 1'b1);
        #1;
        expect_grant("post_reset_w", 2, 4);
        next_cycle();

        clr();
        #1;
        expect_grant("idle_end", 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Request rows must be one-hot or empty.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            assert ($onehot0(req[i])) else begin
                errors++;
                $error("FAIL req_onehot row=%0d observed=%b expected=onehot0", i, req[i]);
            end
        end
    end

endmodule
